// File: rtl/gato_pkg.sv
// Shared definitions for the tic-tac-toe board evaluator: cell codes,
// the "no line" marker and the line-to-cell lookup table.
package gato_pkg;

  localparam logic [1:0] CELDA_VACIA = 2'b00;
  localparam logic [1:0] CELDA_X     = 2'b01;
  localparam logic [1:0] CELDA_O     = 2'b10;

  localparam logic [3:0] LINEA_NINGUNA = 4'hF;
  localparam int         NUM_LINEAS    = 8;
  localparam int         NUM_CELDAS    = 9;

  typedef logic [3:0] idx_celda_t;

  // Zero-based cell indices (cell 1 -> 0 ... cell 9 -> 8) for each line.
  localparam idx_celda_t TABLA_LINEAS [NUM_LINEAS][3] = '{
    '{4'd0, 4'd1, 4'd2},
    '{4'd3, 4'd4, 4'd5},
    '{4'd6, 4'd7, 4'd8},
    '{4'd0, 4'd3, 4'd6},
    '{4'd1, 4'd4, 4'd7},
    '{4'd2, 4'd5, 4'd8},
    '{4'd0, 4'd4, 4'd8},
    '{4'd2, 4'd4, 4'd6}
  };

  // A cell counts as occupied only when it holds a real player code.
  function automatic logic celda_jugador(input logic [1:0] celda);
    return (celda == CELDA_X) || (celda == CELDA_O);
  endfunction

endpackage

// File: rtl/evaluador_juego_if.sv
// Board/result bundle between the game register block and the evaluator.
interface evaluador_juego_if;
  logic       start_in;
  logic [1:0] c1_in, c2_in, c3_in, c4_in, c5_in, c6_in, c7_in, c8_in, c9_in;
  logic       busy_out;
  logic       done_out;
  logic [1:0] winner_out;
  logic [3:0] line_out;
  logic       draw_out;

  modport master (
    output start_in, c1_in, c2_in, c3_in, c4_in, c5_in, c6_in, c7_in, c8_in, c9_in,
    input  busy_out, done_out, winner_out, line_out, draw_out
  );

  modport slave (
    input  start_in, c1_in, c2_in, c3_in, c4_in, c5_in, c6_in, c7_in, c8_in, c9_in,
    output busy_out, done_out, winner_out, line_out, draw_out
  );
endinterface

// File: rtl/comparador_linea.sv
// Combinational single-line checker: reports the player owning all three
// cells, or CELDA_VACIA when the line is not a win.
module comparador_linea
  import gato_pkg::*;
(
  input  logic [1:0] celda_a,
  input  logic [1:0] celda_b,
  input  logic [1:0] celda_c,
  output logic [1:0] ganador
);

  // Code 11 is excluded by celda_jugador, so an all-invalid line never wins.
  assign ganador = ((celda_a == celda_b) && (celda_b == celda_c) && celda_jugador(celda_a))
                   ? celda_a : CELDA_VACIA;

endmodule

// File: rtl/evaluador_juego.sv
// Sequential tic-tac-toe evaluator: snapshots the board, scans one line per
// cycle and reports winner/line/draw. Define EVALUADOR_EARLY_EXIT_EN to stop
// the scan at the first winning line; otherwise all 8 lines are always scanned.
module evaluador_juego
  import gato_pkg::*;
(
  input  logic              clk,
  input  logic              reset_in,
  evaluador_juego_if.slave  bus
);

  localparam logic [1:0] EST_IDLE    = 2'd0;
  localparam logic [1:0] EST_CAPTURE = 2'd1;
  localparam logic [1:0] EST_SCAN    = 2'd2;
  localparam logic [1:0] EST_DONE    = 2'd3;

  logic [1:0] estado;
  logic [2:0] indice;
  logic [1:0] tablero [NUM_CELDAS];

  logic       hallado;
  logic [1:0] gan_guardado;
  logic [2:0] lin_guardada;

  logic [1:0] winner_q;
  logic [3:0] line_q;
  logic       draw_q;

  logic [1:0] cel_a, cel_b, cel_c, gan_linea;
  logic       hay_ganador, fin_scan, tablero_lleno;
  logic [1:0] gan_final;
  logic [3:0] lin_final;

  assign cel_a = tablero[TABLA_LINEAS[indice][0]];
  assign cel_b = tablero[TABLA_LINEAS[indice][1]];
  assign cel_c = tablero[TABLA_LINEAS[indice][2]];

  comparador_linea u_comparador (
    .celda_a (cel_a),
    .celda_b (cel_b),
    .celda_c (cel_c),
    .ganador (gan_linea)
  );

  assign hay_ganador = (gan_linea != CELDA_VACIA);

`ifdef EVALUADOR_EARLY_EXIT_EN
  assign fin_scan = hay_ganador || (indice == 3'd7);
`else
  assign fin_scan = (indice == 3'd7);
`endif

  // NOTE: every variable gets a default before the loop so no latch is inferred.
  always_comb begin
    tablero_lleno = 1'b1;
    for (int i = 0; i < NUM_CELDAS; i++)
      tablero_lleno = tablero_lleno & celda_jugador(tablero[i]);
  end

  // An earlier win recorded during the scan always beats the current line.
  always_comb begin
    gan_final = gan_linea;
    lin_final = hay_ganador ? {1'b0, indice} : LINEA_NINGUNA;
    if (hallado) begin
      gan_final = gan_guardado;
      lin_final = {1'b0, lin_guardada};
    end
  end

  // NOTE: the board snapshot is pure datapath, written before it is read, so it carries no reset.
  always_ff @(posedge clk) begin
    if (estado == EST_CAPTURE) begin
      tablero[0] <= bus.c1_in;
      tablero[1] <= bus.c2_in;
      tablero[2] <= bus.c3_in;
      tablero[3] <= bus.c4_in;
      tablero[4] <= bus.c5_in;
      tablero[5] <= bus.c6_in;
      tablero[6] <= bus.c7_in;
      tablero[7] <= bus.c8_in;
      tablero[8] <= bus.c9_in;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset_in) begin
      estado       <= EST_IDLE;
      indice       <= 3'd0;
      hallado      <= 1'b0;
      gan_guardado <= CELDA_VACIA;
      lin_guardada <= 3'd0;
      winner_q     <= CELDA_VACIA;
      line_q       <= LINEA_NINGUNA;
      draw_q       <= 1'b0;
    end else begin
      case (estado)
        EST_IDLE: begin
          if (bus.start_in) estado <= EST_CAPTURE;
        end
        EST_CAPTURE: begin
          indice  <= 3'd0;
          hallado <= 1'b0;
          estado  <= EST_SCAN;
        end
        EST_SCAN: begin
          if (hay_ganador && !hallado) begin
            hallado      <= 1'b1;
            gan_guardado <= gan_linea;
            lin_guardada <= indice;
          end
          if (fin_scan) begin
            estado   <= EST_DONE;
            winner_q <= gan_final;
            line_q   <= lin_final;
            draw_q   <= (gan_final == CELDA_VACIA) && tablero_lleno;
          end else begin
            indice <= indice + 3'd1;
          end
        end
        default: estado <= EST_IDLE;
      endcase
    end
  end

  assign bus.busy_out   = (estado != EST_IDLE);
  assign bus.done_out   = (estado == EST_DONE);
  assign bus.winner_out = winner_q;
  assign bus.line_out   = line_q;
  assign bus.draw_out   = draw_q;

endmodule
